result_wb_arbiter: RTL and testbench
====================================

// Module: result_wb_arbiter
// PURPOSE
//  Merges result uops from NUM_PORTS functional units (ALU, Multiply, Divide, ...) onto one registered writeback bus.
//  Sits directly downstream of the pipelined multiplier and its siblings.
//  Provides each unit's IN_wbStall via OUT_wbStall, holds one pending result per port, arbitrates round-robin,
//  and drops results squashed by a mispredicted branch.
// PARAMETERS
//  NUM_PORTS  3   number of functional-unit result ports (2..8)
//  UOP_W      92  result-uop width; [0]=valid, [48:43]=sqN, [91:60]=result, remaining fields passed through untouched
// PORTS
//  clk          in   1              clock, rising edge
//  rst          in   1              asynchronous reset, active-high
//  IN_branch    in   52             branch bus; [51]=taken/flush, [18:13]=branch sqN
//  IN_uop       in   NUM_PORTS*92   per-port result uop, port p at [p*92 +: 92]
//  OUT_wbStall  out  NUM_PORTS      per-port stall back to unit p (unit holds its output while high)
//  OUT_uop      out  92             registered writeback uop to register file / ROB
//  OUT_stallCnt out  16             saturating count of cycles with any OUT_wbStall bit high
// BEHAVIOUR
//  Reset (async): all buffer valid bits=0, rr pointer=0, OUT_uop=0 (valid bit 0), OUT_stallCnt=0.
//    OUT_wbStall is therefore 0 immediately.
//  Per port p, one holding buffer buf[p] with valid bit bv[p].
//  Squash test: killed(x) = IN_branch[51] && $signed(x.sqN - IN_branch[18:13]) > 0 (6-bit wrap arithmetic).
//  Grant (combinational, from registered state only):
//    first p with bv[p] && !killed(buf[p]), searching rr, rr+1, ... mod NUM_PORTS; at most one grant.
//  OUT_wbStall[p] = bv[p] && !grant[p].
//    No combinational path from IN_uop to OUT_wbStall.
//  Capture: IN_uop[p] is accepted iff valid && !OUT_wbStall[p] && !killed(IN_uop[p]).
//    A uop presented while stalled is ignored; the unit re-presents it.
//  Buffer update per edge: if accepted, bv[p]<=1 and buf[p]<=IN_uop[p]. This overrides a drain in the same cycle.
//    Otherwise, if granted or killed(buf[p]), bv[p]<=0.
//  Output register: if a grant exists, OUT_uop<=buf[g] with valid=1 and rr<=(g+1) mod NUM_PORTS. Otherwise OUT_uop[0]<=0.
//    Other fields of OUT_uop hold their values. rr changes only on a grant.
//  Latency: unit output accepted at edge N appears on OUT_uop after edge N+1 at the earliest (1 buffered cycle).
//    A single active port sustains 1 result/cycle.
//  Killed buffer entries are never granted and are cleared the same edge. An already-written OUT_uop is not recalled.
//  Simultaneous flush and capture: the kill check on the incoming uop applies. An older uop is captured; a younger one is dropped.
//  OUT_stallCnt increments when |OUT_wbStall and saturates at 16'hFFFF.
//  Reset mid-operation: all pending results are discarded, with no partial OUT_uop.
// TESTING
//  1. Port 1 only, valid uop sqN=5 result=32'hDEADBEEF every cycle.
//     -> OUT_wbStall=0 always; OUT_uop result=DEADBEEF, valid 1 each cycle one edge after capture.
//  2. Ports 0,1,2 present in the same cycle, rr=0.
//     -> Outputs in order p0,p1,p2 on 3 consecutive cycles.
//     -> OUT_wbStall = 3'b110, then 3'b100, then 3'b000; OUT_stallCnt=2.
//  3. Buffers hold sqN 10 (p0) and 14 (p1); IN_branch[51]=1 with sqN=12.
//     -> p0 written; p1 dropped; OUT_wbStall returns 0; no OUT_uop with sqN 14.
//  4. Wrap: buffer sqN=6'd62, branch sqN=6'd1, taken.
//     -> Not killed ($signed(62-1)=-3), so it is written back.
//     -> Incoming sqN=6'd2 in the same cycle is not captured.
//  5. Hold a stalled port for 70000 cycles.
//     -> OUT_stallCnt saturates at 65535; asserting rst mid-stream clears bv, OUT_uop[0] and the counter asynchronously.
//  6. Unit keeps stalled uop stable for 2 cycles while another port wins.
//     -> Exactly one OUT_uop for it; no duplicate capture.

Source files
------------

// File: rtl/result_wb_arbiter_if.sv
// Writeback arbiter bus: per-unit result uops and branch bus in, per-unit stall and
// the merged writeback uop out. The master side is the functional-unit cluster.
interface result_wb_arbiter_if #(
   parameter int NUM_PORTS = 3,
   parameter int UOP_W     = 92
);
   logic [51:0]                IN_branch;
   logic [NUM_PORTS*UOP_W-1:0] IN_uop;
   logic [NUM_PORTS-1:0]       OUT_wbStall;
   logic [UOP_W-1:0]           OUT_uop;
   logic [15:0]                OUT_stallCnt;

   modport master (
      output IN_branch,
      output IN_uop,
      input  OUT_wbStall,
      input  OUT_uop,
      input  OUT_stallCnt
   );

   modport slave (
      input  IN_branch,
      input  IN_uop,
      output OUT_wbStall,
      output OUT_uop,
      output OUT_stallCnt
   );
endinterface

// File: rtl/result_wb_arbiter.sv
// Merges result uops from several functional units onto one registered writeback bus,
// with one holding buffer per unit, round-robin grant and branch-squash filtering.
module result_wb_arbiter #(
   parameter int NUM_PORTS = 3,
   parameter int UOP_W     = 92
) (
   input  logic               clk,
   input  logic               rst,
   result_wb_arbiter_if.slave wb
);
   localparam int PTR_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
   localparam int SQN_LSB    = 43;
   localparam int SQN_W      = 6;
   localparam int BR_FLUSH   = 51;
   localparam int BR_SQN_LSB = 13;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [PTR_W:0]   ptr_ext_t;
   typedef logic [UOP_W-1:0] uop_t;

   localparam ptr_ext_t NUM_PORTS_EXT = ptr_ext_t'(NUM_PORTS);

   // A uop is younger than the branch when its sqN lies strictly ahead in 6-bit wrap order.
   function automatic logic is_killed(input logic flush, input logic [SQN_W-1:0] br_sqn,
                                      input logic [SQN_W-1:0] sqn);
      logic [SQN_W-1:0] diff;
      diff = sqn - br_sqn;
      return flush && ($signed(diff) > $signed(6'd0));
   endfunction

   uop_t                 hold_q [NUM_PORTS];
   uop_t                 hold_d [NUM_PORTS];
   logic [NUM_PORTS-1:0] bv_q;
   logic [NUM_PORTS-1:0] bv_d;
   ptr_t                 rr_q;
   ptr_t                 rr_d;
   uop_t                 out_uop_q;
   uop_t                 out_uop_d;
   logic [15:0]          stall_cnt_q;
   logic [15:0]          stall_cnt_d;

   uop_t                 in_uop [NUM_PORTS];
   logic [NUM_PORTS-1:0] in_killed;
   logic [NUM_PORTS-1:0] hold_killed;
   logic [NUM_PORTS-1:0] eligible;
   logic [NUM_PORTS-1:0] grant;
   logic [NUM_PORTS-1:0] stall;
   logic [NUM_PORTS-1:0] accept;
   logic                 grant_any;
   ptr_t                 grant_idx;

   logic                 br_flush;
   logic [SQN_W-1:0]     br_sqn;
   logic                 unused_branch_bits;

   assign br_flush           = wb.IN_branch[BR_FLUSH];
   assign br_sqn             = wb.IN_branch[BR_SQN_LSB +: SQN_W];
   assign unused_branch_bits = ^{wb.IN_branch[50:19], wb.IN_branch[12:0]};

   generate
      for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_port
         assign in_uop[gi]      = wb.IN_uop[gi*UOP_W +: UOP_W];
         assign in_killed[gi]   = is_killed(br_flush, br_sqn, in_uop[gi][SQN_LSB +: SQN_W]);
         assign hold_killed[gi] = is_killed(br_flush, br_sqn, hold_q[gi][SQN_LSB +: SQN_W]);
         assign eligible[gi]    = bv_q[gi] && !hold_killed[gi];
         // Stall depends only on registered buffer state, never on the incoming uop.
         assign stall[gi]       = bv_q[gi] && !grant[gi];
         assign accept[gi]      = in_uop[gi][0] && !stall[gi] && !in_killed[gi];
      end
   endgenerate

   // Round-robin search starting at rr_q; first eligible buffer wins.
   always_comb begin
      ptr_ext_t idx;
      idx       = '0;
      grant     = '0;
      grant_any = 1'b0;
      grant_idx = '0;
      for (int k = 0; k < NUM_PORTS; k++) begin
         idx = {1'b0, rr_q} + ptr_ext_t'(k);
         if (idx >= NUM_PORTS_EXT) begin
            idx = idx - NUM_PORTS_EXT;
         end
         if (!grant_any && eligible[idx[PTR_W-1:0]]) begin
            grant_any = 1'b1;
            grant_idx = idx[PTR_W-1:0];
         end
      end
      if (grant_any) begin
         grant[grant_idx] = 1'b1;
      end
   end

   always_comb begin
      ptr_ext_t rr_next;
      rr_next     = {1'b0, grant_idx} + ptr_ext_t'(1);
      bv_d        = bv_q;
      hold_d      = hold_q;
      rr_d        = rr_q;
      out_uop_d   = out_uop_q;
      stall_cnt_d = stall_cnt_q;

      // A fresh capture wins over a drain of the same buffer.
      for (int p = 0; p < NUM_PORTS; p++) begin
         if (accept[p]) begin
            bv_d[p]   = 1'b1;
            hold_d[p] = in_uop[p];
         end else if (grant[p] || hold_killed[p]) begin
            bv_d[p] = 1'b0;
         end
      end

      out_uop_d[0] = 1'b0;
      if (grant_any) begin
         out_uop_d    = hold_q[grant_idx];
         out_uop_d[0] = 1'b1;
         if (rr_next >= NUM_PORTS_EXT) begin
            rr_d = '0;
         end else begin
            rr_d = rr_next[PTR_W-1:0];
         end
      end

      if ((|stall) && (stall_cnt_q != 16'hFFFF)) begin
         stall_cnt_d = stall_cnt_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bv_q        <= '0;
         rr_q        <= '0;
         out_uop_q   <= '0;
         stall_cnt_q <= '0;
         for (int p = 0; p < NUM_PORTS; p++) begin
            hold_q[p] <= '0;
         end
      end else begin
         bv_q        <= bv_d;
         rr_q        <= rr_d;
         out_uop_q   <= out_uop_d;
         stall_cnt_q <= stall_cnt_d;
         for (int p = 0; p < NUM_PORTS; p++) begin
            hold_q[p] <= hold_d[p];
         end
      end
   end

   assign wb.OUT_wbStall  = stall;
   assign wb.OUT_uop      = out_uop_q;
   assign wb.OUT_stallCnt = stall_cnt_q;
endmodule

// File: tb/tb_result_wb_arbiter.sv
// Directed bench for result_wb_arbiter: one task per scenario, expected values worked out by hand.
module tb_result_wb_arbiter;
   localparam int NP = 3;
   localparam int UW = 92;

   logic clk = 1'b0;
   logic rst;
   int   n_vec = 0;
   int   n_err = 0;

   always #5 clk = ~clk;

   result_wb_arbiter_if #(.NUM_PORTS(NP), .UOP_W(UW)) bus ();

   result_wb_arbiter #(.NUM_PORTS(NP), .UOP_W(UW)) dut (
      .clk (clk),
      .rst (rst),
      .wb  (bus)
   );

   // Per-cycle inputs (result, 0 = idle) and expectations for the back-to-back scenario.
   localparam logic [31:0] B2B_IN [7][3] = '{
      '{32'hA0, 32'hB0, 32'hC0},
      '{32'hA1, 32'h0,  32'hC1},
      '{32'h0,  32'h0,  32'hC1},
      '{32'h0,  32'h0,  32'hC1},
      '{32'h0,  32'h0,  32'h0},
      '{32'h0,  32'h0,  32'h0},
      '{32'h0,  32'h0,  32'h0}
   };
   localparam logic [2:0]  B2B_STALL [7] = '{3'b110, 3'b101, 3'b001, 3'b100, 3'b000, 3'b000, 3'b000};
   localparam logic [31:0] B2B_OUT   [7] = '{32'h0, 32'hA0, 32'hB0, 32'hC0, 32'hA1, 32'hC1, 32'h0};

   function automatic logic [UW-1:0] mk_uop(input logic v, input logic [5:0] sqn, input logic [31:0] res);
      logic [UW-1:0] u;
      u          = '0;
      u[0]       = v;
      u[42:1]    = 42'h2A5_5A5A_1234;
      u[48:43]   = sqn;
      u[59:49]   = 11'h3C5;
      u[91:60]   = res;
      return u;
   endfunction

   task automatic set_port(input int p, input logic [UW-1:0] u);
      bus.IN_uop[p*UW +: UW] = u;
   endtask

   task automatic set_branch(input logic taken, input logic [5:0] sqn);
      bus.IN_branch         = '0;
      bus.IN_branch[51]     = taken;
      bus.IN_branch[18:13]  = sqn;
   endtask

   task automatic clear_inputs();
      bus.IN_uop    = '0;
      bus.IN_branch = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b1;
      #2;
      rst = 1'b0;
      step();
   endtask

   task automatic test_reset();
      set_port(0, mk_uop(1'b1, 6'd3, 32'h1234));
      #1;
      n_vec++;
      if (bus.OUT_uop !== '0) begin
         n_err++;
         $display("FAIL reset_out_uop got=%h want=0", bus.OUT_uop);
      end
      n_vec++;
      if (bus.OUT_stallCnt !== 16'd0) begin
         n_err++;
         $display("FAIL reset_cnt got=%0d want=0", bus.OUT_stallCnt);
      end
      step();
      step();
      n_vec++;
      if (bus.OUT_wbStall !== 3'b000 || bus.OUT_uop[0] !== 1'b0) begin
         n_err++;
         $display("FAIL reset_held stall=%b valid=%b want stall=000 valid=0", bus.OUT_wbStall, bus.OUT_uop[0]);
      end
      $display("test_reset: stall=%b valid=%b cnt=%0d", bus.OUT_wbStall, bus.OUT_uop[0], bus.OUT_stallCnt);
      clear_inputs();
      rst = 1'b0;
      step();
   endtask

   task automatic test_single_port();
      logic [UW-1:0] exp_u;
      exp_u = mk_uop(1'b1, 6'd5, 32'hDEADBEEF);
      do_reset();
      set_port(1, exp_u);
      step();
      n_vec++;
      if (bus.OUT_uop[0] !== 1'b0 || bus.OUT_wbStall !== 3'b000) begin
         n_err++;
         $display("FAIL single_first valid=%b stall=%b want valid=0 stall=000", bus.OUT_uop[0], bus.OUT_wbStall);
      end
      for (int i = 0; i < 5; i++) begin
         step();
         n_vec++;
         if (bus.OUT_uop !== exp_u || bus.OUT_wbStall !== 3'b000) begin
            n_err++;
            $display("FAIL single_stream[%0d] got=%h stall=%b want=%h stall=000", i, bus.OUT_uop, bus.OUT_wbStall, exp_u);
         end
         $display("test_single_port[%0d]: valid=%b result=%h stall=%b", i, bus.OUT_uop[0], bus.OUT_uop[91:60], bus.OUT_wbStall);
      end
      clear_inputs();
      step();
      step();
      n_vec++;
      if (bus.OUT_uop[0] !== 1'b0) begin
         n_err++;
         $display("FAIL single_drain valid=%b want=0", bus.OUT_uop[0]);
      end
   endtask

   task automatic test_round_robin();
      logic [31:0] exp_res   [3] = '{32'h100, 32'h101, 32'h102};
      logic [5:0]  exp_sqn   [3] = '{6'd1, 6'd2, 6'd3};
      logic [2:0]  exp_stall [3] = '{3'b100, 3'b000, 3'b000};
      do_reset();
      for (int p = 0; p < 3; p++) begin
         set_port(p, mk_uop(1'b1, exp_sqn[p], exp_res[p]));
      end
      step();
      clear_inputs();
      n_vec++;
      if (bus.OUT_wbStall !== 3'b110 || bus.OUT_uop[0] !== 1'b0 || bus.OUT_stallCnt !== 16'd0) begin
         n_err++;
         $display("FAIL rr_capture stall=%b valid=%b cnt=%0d want stall=110 valid=0 cnt=0",
                  bus.OUT_wbStall, bus.OUT_uop[0], bus.OUT_stallCnt);
      end
      for (int k = 0; k < 3; k++) begin
         step();
         n_vec++;
         if (bus.OUT_uop[0] !== 1'b1 || bus.OUT_uop[91:60] !== exp_res[k] ||
             bus.OUT_uop[48:43] !== exp_sqn[k] || bus.OUT_wbStall !== exp_stall[k]) begin
            n_err++;
            $display("FAIL rr_order[%0d] valid=%b result=%h sqn=%0d stall=%b want result=%h sqn=%0d stall=%b",
                     k, bus.OUT_uop[0], bus.OUT_uop[91:60], bus.OUT_uop[48:43], bus.OUT_wbStall,
                     exp_res[k], exp_sqn[k], exp_stall[k]);
         end
         $display("test_round_robin[%0d]: result=%h stall=%b cnt=%0d", k, bus.OUT_uop[91:60], bus.OUT_wbStall, bus.OUT_stallCnt);
      end
      n_vec++;
      if (bus.OUT_stallCnt !== 16'd2) begin
         n_err++;
         $display("FAIL rr_stallcnt got=%0d want=2", bus.OUT_stallCnt);
      end
      step();
      n_vec++;
      if (bus.OUT_uop[0] !== 1'b0) begin
         n_err++;
         $display("FAIL rr_idle valid=%b want=0", bus.OUT_uop[0]);
      end
   endtask

   task automatic test_flush();
      do_reset();
      set_port(0, mk_uop(1'b1, 6'd10, 32'h10));
      set_port(1, mk_uop(1'b1, 6'd14, 32'h14));
      step();
      clear_inputs();
      set_branch(1'b1, 6'd12);
      #1;
      n_vec++;
      if (bus.OUT_wbStall !== 3'b010) begin
         n_err++;
         $display("FAIL flush_stall got=%b want=010", bus.OUT_wbStall);
      end
      step();
      n_vec++;
      if (bus.OUT_uop[0] !== 1'b1 || bus.OUT_uop[48:43] !== 6'd10 || bus.OUT_uop[91:60] !== 32'h10) begin
         n_err++;
         $display("FAIL flush_older valid=%b sqn=%0d result=%h want valid=1 sqn=10 result=10",
                  bus.OUT_uop[0], bus.OUT_uop[48:43], bus.OUT_uop[91:60]);
      end
      clear_inputs();
      #1;
      n_vec++;
      if (bus.OUT_wbStall !== 3'b000) begin
         n_err++;
         $display("FAIL flush_stall_clear got=%b want=000", bus.OUT_wbStall);
      end
      for (int i = 0; i < 3; i++) begin
         step();
         n_vec++;
         if (bus.OUT_uop[0] !== 1'b0) begin
            n_err++;
            $display("FAIL flush_dropped[%0d] valid=%b sqn=%0d want valid=0", i, bus.OUT_uop[0], bus.OUT_uop[48:43]);
         end
      end
      $display("test_flush: stall=%b valid=%b", bus.OUT_wbStall, bus.OUT_uop[0]);
   endtask

   task automatic test_wrap();
      do_reset();
      set_port(0, mk_uop(1'b1, 6'd62, 32'h62));
      step();
      clear_inputs();
      set_branch(1'b1, 6'd1);
      set_port(1, mk_uop(1'b1, 6'd2, 32'h2));
      set_port(2, mk_uop(1'b1, 6'd63, 32'h63));
      #1;
      n_vec++;
      if (bus.OUT_wbStall !== 3'b000) begin
         n_err++;
         $display("FAIL wrap_stall got=%b want=000", bus.OUT_wbStall);
      end
      step();
      clear_inputs();
      n_vec++;
      if (bus.OUT_uop[0] !== 1'b1 || bus.OUT_uop[48:43] !== 6'd62 || bus.OUT_uop[91:60] !== 32'h62) begin
         n_err++;
         $display("FAIL wrap_kept valid=%b sqn=%0d want valid=1 sqn=62", bus.OUT_uop[0], bus.OUT_uop[48:43]);
      end
      step();
      n_vec++;
      if (bus.OUT_uop[0] !== 1'b1 || bus.OUT_uop[48:43] !== 6'd63) begin
         n_err++;
         $display("FAIL wrap_older_captured valid=%b sqn=%0d want valid=1 sqn=63", bus.OUT_uop[0], bus.OUT_uop[48:43]);
      end
      step();
      n_vec++;
      if (bus.OUT_uop[0] !== 1'b0) begin
         n_err++;
         $display("FAIL wrap_younger_dropped valid=%b sqn=%0d want valid=0", bus.OUT_uop[0], bus.OUT_uop[48:43]);
      end
      $display("test_wrap: last valid=%b sqn=%0d", bus.OUT_uop[0], bus.OUT_uop[48:43]);
   endtask

   task automatic test_saturate();
      do_reset();
      for (int p = 0; p < 3; p++) begin
         set_port(p, mk_uop(1'b1, 6'd0, 32'h500 + p));
      end
      step();
      n_vec++;
      if (bus.OUT_wbStall !== 3'b110 || bus.OUT_stallCnt !== 16'd0) begin
         n_err++;
         $display("FAIL sat_start stall=%b cnt=%0d want stall=110 cnt=0", bus.OUT_wbStall, bus.OUT_stallCnt);
      end
      repeat (99) step();
      n_vec++;
      if (bus.OUT_stallCnt !== 16'd99) begin
         n_err++;
         $display("FAIL sat_count got=%0d want=99", bus.OUT_stallCnt);
      end
      repeat (65500) step();
      n_vec++;
      if (bus.OUT_stallCnt !== 16'hFFFF) begin
         n_err++;
         $display("FAIL sat_max got=%0d want=65535", bus.OUT_stallCnt);
      end
      step();
      n_vec++;
      if (bus.OUT_stallCnt !== 16'hFFFF || bus.OUT_wbStall === 3'b000) begin
         n_err++;
         $display("FAIL sat_hold cnt=%0d stall=%b want cnt=65535 stall!=000", bus.OUT_stallCnt, bus.OUT_wbStall);
      end
      $display("test_saturate: cnt=%0d stall=%b", bus.OUT_stallCnt, bus.OUT_wbStall);
      #3;
      rst = 1'b1;
      #1;
      n_vec++;
      if (bus.OUT_stallCnt !== 16'd0 || bus.OUT_uop[0] !== 1'b0 || bus.OUT_wbStall !== 3'b000) begin
         n_err++;
         $display("FAIL sat_async_reset cnt=%0d valid=%b stall=%b want 0/0/000",
                  bus.OUT_stallCnt, bus.OUT_uop[0], bus.OUT_wbStall);
      end
      clear_inputs();
      rst = 1'b0;
      step();
      step();
      n_vec++;
      if (bus.OUT_uop[0] !== 1'b0 || bus.OUT_stallCnt !== 16'd0) begin
         n_err++;
         $display("FAIL sat_after_reset valid=%b cnt=%0d want 0/0", bus.OUT_uop[0], bus.OUT_stallCnt);
      end
   endtask

   task automatic test_back_to_back();
      int c1_seen;
      c1_seen = 0;
      do_reset();
      for (int k = 0; k < 7; k++) begin
         clear_inputs();
         for (int p = 0; p < 3; p++) begin
            if (B2B_IN[k][p] != 32'h0) begin
               set_port(p, mk_uop(1'b1, 6'd0, B2B_IN[k][p]));
            end
         end
         step();
         if (bus.OUT_uop[0] === 1'b1 && bus.OUT_uop[91:60] === 32'hC1) begin
            c1_seen++;
         end
         n_vec++;
         if (bus.OUT_wbStall !== B2B_STALL[k] || bus.OUT_uop[0] !== (B2B_OUT[k] != 32'h0) ||
             (B2B_OUT[k] != 32'h0 && bus.OUT_uop[91:60] !== B2B_OUT[k])) begin
            n_err++;
            $display("FAIL b2b[%0d] stall=%b valid=%b result=%h want stall=%b result=%h",
                     k, bus.OUT_wbStall, bus.OUT_uop[0], bus.OUT_uop[91:60], B2B_STALL[k], B2B_OUT[k]);
         end
         $display("test_back_to_back[%0d]: stall=%b valid=%b result=%h", k, bus.OUT_wbStall, bus.OUT_uop[0], bus.OUT_uop[91:60]);
      end
      clear_inputs();
      n_vec++;
      if (c1_seen != 1) begin
         n_err++;
         $display("FAIL b2b_single_writeback count=%0d want=1", c1_seen);
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      clear_inputs();
      test_reset();
      test_single_port();
      test_round_robin();
      test_flush();
      test_wrap();
      test_back_to_back();
      test_saturate();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
